// File: rtl/axilite_noc_request.sv
// AXI-Lite AR/AW/W front end that issues OpenPiton non-cacheable NoC requests.
// Each packet also pushes a {type, addr[3]} descriptor to the response side.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`endif
`ifndef MSG_TYPE_NC_STORE_REQ
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`define MSG_ADDR 63:16
`define MSG_DATA_SIZE 15:13
`define MSG_SRC_CHIPID 63:50
`define MSG_SRC_X 49:42
`define MSG_SRC_Y 41:34
`endif

module axilite_noc_request #(
    parameter int          AXI_LITE_DATA_WIDTH = 64,
    parameter int          AXI_LITE_ADDR_WIDTH = 64,
    parameter logic [2:0]  REQ_DATA_SIZE       = 3'b011,
    parameter logic [13:0] SRC_CHIPID          = '0,
    parameter logic [7:0]  SRC_X               = '0,
    parameter logic [7:0]  SRC_Y               = '0,
    parameter logic [13:0] DST_CHIPID          = '0,
    parameter logic [7:0]  DST_X               = '0,
    parameter logic [7:0]  DST_Y               = '0,
    parameter logic [1:0]  MSG_TYPE_LOAD       = 2'd1,
    parameter logic [1:0]  MSG_TYPE_STORE      = 2'd2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic                               noc_valid_out,
    output logic [`NOC_DATA_WIDTH-1:0]         noc_data_out,
    input  logic                               noc_ready_in,
    output logic [2:0]                         transaction_type_wr_data,
    output logic                               transaction_type_wr,
    input  logic                               type_fifo_full
);

    localparam int NW         = `NOC_DATA_WIDTH;
    localparam int PHY_W      = `PHY_ADDR_WIDTH;
    localparam int DATA_FLITS = AXI_LITE_DATA_WIDTH / NW;
    localparam int CNT_W      = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
    localparam logic [7:0] LOAD_LEN  = 8'd2;
    localparam logic [7:0] STORE_LEN = 8'(2 + DATA_FLITS);
    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(DATA_FLITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        DATA
    } state_t;

    state_t                         state_q;
    logic                           ar_full_q;
    logic [PHY_W-1:0]               ar_addr_q;
    logic                           aw_full_q;
    logic [PHY_W-1:0]               aw_addr_q;
    logic                           w_full_q;
    logic [AXI_LITE_DATA_WIDTH-1:0] w_data_q;
    logic                           favor_load_q;
    logic                           is_store_q;
    logic [PHY_W-1:0]               pkt_addr_q;
    logic [AXI_LITE_DATA_WIDTH-1:0] pkt_data_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           valid_q;
    logic [NW-1:0]                  data_q;

    logic ar_hs, aw_hs, w_hs;
    logic load_pend, store_pend, pick_load;
    logic flit_acc, last_acc, grant;
    logic rel_ar, rel_st;
    logic unused_inputs;

    function automatic logic [NW-1:0] bswap(input logic [NW-1:0] w);
        logic [NW-1:0] r;
        r = '0;
        for (int i = 0; i < NW / 8; i++) begin
            r[8*i +: 8] = w[8*(NW/8-1-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] word_at(
        input logic [AXI_LITE_DATA_WIDTH-1:0] d,
        input int k
    );
        return bswap(NW'(d >> (NW * k)));
    endfunction

    function automatic logic [NW-1:0] hdr0(input logic st);
        logic [NW-1:0] h;
        h = '0;
        h[`MSG_DST_CHIPID] = DST_CHIPID;
        h[`MSG_DST_X]      = DST_X;
        h[`MSG_DST_Y]      = DST_Y;
        h[`MSG_LENGTH]     = st ? STORE_LEN : LOAD_LEN;
        h[`MSG_TYPE]       = st ? `MSG_TYPE_NC_STORE_REQ
                                : `MSG_TYPE_NC_LOAD_REQ;
        h[`MSG_MSHRID]     = 8'd0;
        return h;
    endfunction

    function automatic logic [NW-1:0] hdr1(input logic [PHY_W-1:0] a);
        logic [NW-1:0] h;
        h = '0;
        h[`MSG_ADDR]      = 48'(a);
        h[`MSG_DATA_SIZE] = REQ_DATA_SIZE;
        return h;
    endfunction

    function automatic logic [NW-1:0] hdr2();
        logic [NW-1:0] h;
        h = '0;
        h[`MSG_SRC_CHIPID] = SRC_CHIPID;
        h[`MSG_SRC_X]      = SRC_X;
        h[`MSG_SRC_Y]      = SRC_Y;
        return h;
    endfunction

    assign s_axi_arready = !ar_full_q && !rst;
    assign s_axi_awready = !aw_full_q && !rst;
    assign s_axi_wready  = !w_full_q && !rst;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    assign load_pend  = ar_full_q;
    assign store_pend = aw_full_q && w_full_q;
    assign pick_load  = load_pend && (!store_pend || favor_load_q);

    // A new grant may ride on the last flit so packets go out back to back.
    assign flit_acc = valid_q && noc_ready_in;
    assign last_acc = flit_acc &&
                      ((state_q == HDR2 && !is_store_q) ||
                       (state_q == DATA && cnt_q == LAST_FLIT));
    assign grant    = !rst && !type_fifo_full &&
                      (load_pend || store_pend) &&
                      (state_q == IDLE || last_acc);

    assign rel_ar = flit_acc && state_q == HDR0 && !is_store_q;
    assign rel_st = flit_acc && state_q == HDR0 && is_store_q;

    assign transaction_type_wr      = grant;
    assign transaction_type_wr_data = pick_load
                                    ? {MSG_TYPE_LOAD, ar_addr_q[3]}
                                    : {MSG_TYPE_STORE, aw_addr_q[3]};

    assign noc_valid_out = valid_q;
    assign noc_data_out  = data_q;

    assign unused_inputs = ^{s_axi_wstrb,
                             s_axi_araddr[AXI_LITE_ADDR_WIDTH-1:PHY_W],
                             s_axi_awaddr[AXI_LITE_ADDR_WIDTH-1:PHY_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ar_full_q    <= 1'b0;
            ar_addr_q    <= '0;
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            favor_load_q <= 1'b1;
            is_store_q   <= 1'b0;
            pkt_addr_q   <= '0;
            pkt_data_q   <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            if (rel_ar) ar_full_q <= 1'b0;
            if (rel_st) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end
            if (ar_hs) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= s_axi_araddr[PHY_W-1:0];
            end
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s_axi_awaddr[PHY_W-1:0];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi_wdata;
            end

            unique case (state_q)
                IDLE: ;
                HDR0: if (flit_acc) begin
                    data_q  <= hdr1(pkt_addr_q);
                    state_q <= HDR1;
                end
                HDR1: if (flit_acc) begin
                    data_q  <= hdr2();
                    state_q <= HDR2;
                end
                HDR2: if (flit_acc) begin
                    if (is_store_q) begin
                        data_q  <= word_at(pkt_data_q, 0);
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DATA: if (flit_acc) begin
                    if (cnt_q == LAST_FLIT) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        data_q <= word_at(pkt_data_q, int'(cnt_q) + 1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (grant) begin
                data_q       <= hdr0(!pick_load);
                valid_q      <= 1'b1;
                state_q      <= HDR0;
                is_store_q   <= !pick_load;
                pkt_addr_q   <= pick_load ? ar_addr_q : aw_addr_q;
                pkt_data_q   <= w_data_q;
                favor_load_q <= !favor_load_q;
            end
        end
    end

endmodule

// File: tb/tb_axilite_noc_request.sv
// Bench for axilite_noc_request: directed plan steps plus a randomized
// load/store stream checked against a per-class in-order packet model.
module tb_axilite_noc_request;

    localparam int NL = 12;
    localparam int NS = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [63:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic        noc_valid_out;
    logic [63:0] noc_data_out;
    logic        noc_ready_in;
    logic [2:0]  transaction_type_wr_data;
    logic        transaction_type_wr;
    logic        type_fifo_full;

    always #5 clk = ~clk;

    axilite_noc_request dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axi_araddr             (s_axi_araddr),
        .s_axi_arvalid            (s_axi_arvalid),
        .s_axi_arready            (s_axi_arready),
        .s_axi_awaddr             (s_axi_awaddr),
        .s_axi_awvalid            (s_axi_awvalid),
        .s_axi_awready            (s_axi_awready),
        .s_axi_wdata              (s_axi_wdata),
        .s_axi_wstrb              (s_axi_wstrb),
        .s_axi_wvalid             (s_axi_wvalid),
        .s_axi_wready             (s_axi_wready),
        .noc_valid_out            (noc_valid_out),
        .noc_data_out             (noc_data_out),
        .noc_ready_in             (noc_ready_in),
        .transaction_type_wr_data (transaction_type_wr_data),
        .transaction_type_wr      (transaction_type_wr),
        .type_fifo_full           (type_fifo_full)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] fl_q[$];
    int          fl_cyc[$];
    logic [2:0]  ds_q[$];
    int          ds_cyc[$];
    logic        stall_q = 1'b0;
    logic [63:0] stall_data = '0;
    logic [63:0] exp_ld[$];
    logic [63:0] exp_aw[$];
    logic [63:0] exp_w[$];

    function automatic logic [63:0] hdr0(input bit st);
        logic [63:0] len;
        logic [63:0] typ;
        len = st ? 64'd3 : 64'd2;
        typ = st ? 64'd15 : 64'd14;
        return (len << 22) | (typ << 14);
    endfunction

    function automatic logic [63:0] hdr1(input logic [63:0] a);
        return ((a & 64'h0000_00FF_FFFF_FFFF) << 16) | (64'd3 << 13);
    endfunction

    function automatic logic [63:0] swap(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted flits and descriptor pushes; check stalled flits hold.
    always @(negedge clk) begin
        if (!rst && noc_valid_out && noc_ready_in) begin
            fl_q.push_back(noc_data_out);
            fl_cyc.push_back(cyc);
        end
        if (!rst && transaction_type_wr) begin
            ds_q.push_back(transaction_type_wr_data);
            ds_cyc.push_back(cyc);
        end
        if (stall_q && !rst) begin
            checks++;
            assert (noc_valid_out === 1'b1 && noc_data_out === stall_data)
            else begin
                errors++;
                $error("FAIL hold observed=%b/%h expected=1/%h",
                       noc_valid_out, noc_data_out, stall_data);
            end
        end
        stall_q    <= !rst && noc_valid_out && !noc_ready_in;
        stall_data <= noc_data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        fl_q.delete();
        fl_cyc.delete();
        ds_q.delete();
        ds_cyc.delete();
    endtask

    task automatic send_ar(input logic [63:0] a);
        int k;
        k = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && k < 500) begin tick(); k++; end
        chk("ar_ready", 64'(s_axi_arready), 64'd1);
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [63:0] a);
        int k;
        k = 0;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && k < 500) begin tick(); k++; end
        chk("aw_ready", 64'(s_axi_awready), 64'd1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d);
        int k;
        k = 0;
        s_axi_wdata  = d;
        s_axi_wstrb  = 8'hFF;
        s_axi_wvalid = 1'b1;
        while (!s_axi_wready && k < 500) begin tick(); k++; end
        chk("w_ready", 64'(s_axi_wready), 64'd1);
        tick();
        s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input string tag);
        int k;
        k = 0;
        while (fl_q.size() < n && k < 2000) begin tick(); k++; end
        chk(tag, 64'(fl_q.size()), 64'(n));
    endtask

    task automatic wait_flit(input logic [63:0] v, input string tag);
        int k;
        k = 0;
        while (!(noc_valid_out && noc_data_out === v) && k < 200) begin
            tick();
            k++;
        end
        chk(tag, noc_data_out, v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a0, a1, d0;
        int idx, li, si, pk;
        bit st;

        rst = 1'b1;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        noc_ready_in = 1'b1;
        type_fifo_full = 1'b0;

        repeat (3) tick();
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_valid", 64'(noc_valid_out), 64'd0);
        chk("rst_data", noc_data_out, 64'd0);
        chk("rst_push", 64'(transaction_type_wr), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready",
            64'({s_axi_arready, s_axi_awready, s_axi_wready}), 64'd7);

        // Single load.
        clear_q();
        send_ar(64'h8000_0008);
        wait_flits(3, "ld_count");
        chk("ld_h0", fl_q[0], hdr0(1'b0));
        chk("ld_h1", fl_q[1], hdr1(64'h8000_0008));
        chk("ld_h2", fl_q[2], 64'd0);
        chk("ld_ndesc", 64'(ds_q.size()), 64'd1);
        chk("ld_desc", 64'(ds_q[0]), 64'b011);
        chk("ld_latency", 64'(fl_cyc[0] - ds_cyc[0]), 64'd1);
        repeat (4) tick();
        chk("ld_no_extra", 64'(fl_q.size()), 64'd3);

        // Single store, W two cycles ahead of AW.
        clear_q();
        send_w(64'h0102_0304_0506_0708);
        tick();
        tick();
        send_aw(64'h8000_0010);
        wait_flits(4, "st_count");
        chk("st_h0", fl_q[0], hdr0(1'b1));
        chk("st_h1", fl_q[1], hdr1(64'h8000_0010));
        chk("st_h2", fl_q[2], 64'd0);
        chk("st_data", fl_q[3], 64'h0807_0605_0403_0201);
        chk("st_desc", 64'(ds_q[0]), 64'b100);
        repeat (4) tick();
        chk("st_no_extra", 64'(fl_q.size()), 64'd4);

        // Load and store pending together; arbiter now favours the load.
        clear_q();
        a0 = 64'h0000_0000_1234_5670;
        a1 = 64'hFFFF_00AB_CDEF_0008;
        d0 = 64'hDEAD_BEEF_CAFE_F00D;
        s_axi_araddr = a0; s_axi_arvalid = 1'b1;
        s_axi_awaddr = a1; s_axi_awvalid = 1'b1;
        s_axi_wdata = d0; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_flits(7, "both_count");
        chk("both_ld_h0", fl_q[0], hdr0(1'b0));
        chk("both_ld_h1", fl_q[1], hdr1(a0));
        chk("both_st_h0", fl_q[3], hdr0(1'b1));
        chk("both_st_h1", fl_q[4], hdr1(a1));
        chk("both_st_d", fl_q[6], swap(d0));
        chk("both_desc0", 64'(ds_q[0]), 64'b010);
        chk("both_desc1", 64'(ds_q[1]), 64'b101);
        for (int i = 0; i < 6; i++)
            chk("both_gap", 64'(fl_cyc[i+1] - fl_cyc[i]), 64'd1);

        // Downstream stall during header1.
        clear_q();
        a0 = 64'h0000_0055_AAAA_5550;
        send_ar(a0);
        wait_flit(hdr1(a0), "stall_reach_h1");
        noc_ready_in = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_h1", noc_data_out, hdr1(a0));
            chk("stall_valid", 64'(noc_valid_out), 64'd1);
        end
        noc_ready_in = 1'b1;
        wait_flits(3, "stall_count");
        chk("stall_f0", fl_q[0], hdr0(1'b0));
        chk("stall_f1", fl_q[1], hdr1(a0));
        chk("stall_f2", fl_q[2], 64'd0);

        // Type FIFO full blocks issue and push.
        repeat (3) tick();
        clear_q();
        type_fifo_full = 1'b1;
        send_ar(64'h8000_0000);
        repeat (5) begin
            tick();
            chk("full_valid", 64'(noc_valid_out), 64'd0);
            chk("full_push", 64'(transaction_type_wr), 64'd0);
        end
        chk("full_nodesc", 64'(ds_q.size()), 64'd0);
        type_fifo_full = 1'b0;
        #1;
        chk("unfull_push", 64'(transaction_type_wr), 64'd1);
        chk("unfull_desc", 64'(transaction_type_wr_data), 64'b010);
        tick();
        chk("unfull_valid", 64'(noc_valid_out), 64'd1);
        chk("unfull_h0", noc_data_out, hdr0(1'b0));
        wait_flits(3, "unfull_count");

        // Reset during a store's data flit, with a load buffered behind it.
        repeat (3) tick();
        clear_q();
        d0 = 64'h1122_3344_5566_7788;
        send_w(d0);
        send_aw(64'h0000_0000_0000_0040);
        wait_flit(hdr0(1'b1), "rst_reach_h0");
        send_ar(64'h0000_0000_0000_0080);
        wait_flit(swap(d0), "rst_reach_data");
        noc_ready_in = 1'b0;
        rst = 1'b1;
        clear_q();
        tick();
        chk("rstmid_valid", 64'(noc_valid_out), 64'd0);
        chk("rstmid_ready",
            64'({s_axi_arready, s_axi_awready, s_axi_wready}), 64'd0);
        rst = 1'b0;
        noc_ready_in = 1'b1;
        #1;
        chk("rstmid_ready_back",
            64'({s_axi_arready, s_axi_awready, s_axi_wready}), 64'd7);
        repeat (10) tick();
        chk("rstmid_no_flits", 64'(fl_q.size()), 64'd0);
        chk("rstmid_no_desc", 64'(ds_q.size()), 64'd0);

        // Randomized mix with random backpressure and FIFO-full.
        clear_q();
        fork
            begin
                logic [63:0] ra;
                for (int i = 0; i < NL; i++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    ra = {$urandom, $urandom};
                    exp_ld.push_back(ra);
                    send_ar(ra);
                end
            end
            begin
                logic [63:0] rb;
                for (int i = 0; i < NS; i++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    rb = {$urandom, $urandom};
                    exp_aw.push_back(rb);
                    send_aw(rb);
                end
            end
            begin
                logic [63:0] rd;
                for (int i = 0; i < NS; i++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    rd = {$urandom, $urandom};
                    exp_w.push_back(rd);
                    send_w(rd);
                end
            end
            begin
                repeat (600) begin
                    noc_ready_in = ($urandom_range(0, 3) != 0);
                    type_fifo_full = ($urandom_range(0, 5) == 0);
                    tick();
                end
                noc_ready_in = 1'b1;
                type_fifo_full = 1'b0;
            end
        join
        wait_flits(3 * NL + 4 * NS, "rnd_count");
        repeat (10) tick();
        chk("rnd_no_extra", 64'(fl_q.size()), 64'(3 * NL + 4 * NS));

        // Loads and stores each leave in arrival order.
        idx = 0; li = 0; si = 0; pk = 0;
        while (idx + 2 < fl_q.size() && pk < ds_q.size()) begin
            st = (fl_q[idx] === hdr0(1'b1));
            chk("rnd_h0", fl_q[idx], st ? hdr0(1'b1) : hdr0(1'b0));
            if (st && si < NS && idx + 3 < fl_q.size()) begin
                chk("rnd_st_h1", fl_q[idx+1], hdr1(exp_aw[si]));
                chk("rnd_st_h2", fl_q[idx+2], 64'd0);
                chk("rnd_st_d", fl_q[idx+3], swap(exp_w[si]));
                chk("rnd_st_desc", 64'(ds_q[pk]), 64'({2'd2, exp_aw[si][3]}));
                si++;
                idx += 4;
            end else if (!st && li < NL) begin
                chk("rnd_ld_h1", fl_q[idx+1], hdr1(exp_ld[li]));
                chk("rnd_ld_h2", fl_q[idx+2], 64'd0);
                chk("rnd_ld_desc", 64'(ds_q[pk]), 64'({2'd1, exp_ld[li][3]}));
                li++;
                idx += 3;
            end else begin
                idx = fl_q.size();
            end
            pk++;
        end
        chk("rnd_loads", 64'(li), 64'(NL));
        chk("rnd_stores", 64'(si), 64'(NS));
        chk("rnd_ndesc", 64'(ds_q.size()), 64'(NL + NS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_noc_request.md
Name: axilite_noc_request

Overview:
- AXI-Lite slave front end that turns AR, AW and W channel requests into OpenPiton non-cacheable NoC request packets.
- Packets are header0/header1/header2, plus data flits for stores.
- Sits ahead of the NoC response path. For every packet it sends, it pushes a 3-bit transaction descriptor into the response side's type FIFO, so returning acks can be routed to the R or B channel.
- B and R responses are out of scope; this block only issues requests.

Parameters:
AXI_LITE_DATA_WIDTH, 64, write/read data width; must be a multiple of `NOC_DATA_WIDTH; DATA_FLITS = AXI_LITE_DATA_WIDTH/`NOC_DATA_WIDTH
AXI_LITE_ADDR_WIDTH, 64, AXI address width; low `PHY_ADDR_WIDTH bits go into header1
REQ_DATA_SIZE, 3'b011, value placed in the header1 data-size field (8 bytes)
SRC_CHIPID/SRC_X/SRC_Y, 0, source tile fields for header2
DST_CHIPID/DST_X/DST_Y, 0, destination fields for header0
MSG_TYPE_LOAD, 2'd1, descriptor type code for loads
MSG_TYPE_STORE, 2'd2, descriptor type code for stores

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_axi_araddr  in  AXI_LITE_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_awaddr  in  AXI_LITE_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  AXI_LITE_DATA_WIDTH  write data
s_axi_wstrb  in  AXI_LITE_DATA_WIDTH/8  write strobes; captured but not encoded, full-word stores only
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
noc_valid_out  out  1  NoC flit valid
noc_data_out  out  `NOC_DATA_WIDTH  NoC flit
noc_ready_in  in  1  NoC downstream ready
transaction_type_wr_data  out  3  descriptor: {type[1:0], addr[3]}
transaction_type_wr  out  1  one-cycle descriptor push strobe
type_fifo_full  in  1  response-side type FIFO full

Behaviour:
- Reset: all ready outputs, noc_valid_out and transaction_type_wr are 0; noc_data_out is 0; all buffers are empty; FSM is IDLE; arbiter favours load.
- Capture buffers:
  - One entry each for AR, AW and W.
  - Each ready output = its buffer is empty and rst is low.
  - A buffer fills on valid&&ready and is released when its packet's header0 is accepted.
- Pending conditions:
  - Load pending = AR buffer full.
  - Store pending = AW and W buffers both full; AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
- IDLE:
  - If type_fifo_full, stay in IDLE.
  - Otherwise, if a load or store is pending, choose one. When both are pending, round-robin: alternate, and the arbiter flips after each grant.
  - On a grant, register header0 into noc_data_out and go to HDR0. The descriptor push happens in the same cycle as the grant.
  - noc_valid_out rises the cycle after the grant.
- Header0 fields:
  - dst chipid/x/y from parameters.
  - `MSG_LENGTH = 2 for a load, 2+DATA_FLITS for a store.
  - `MSG_TYPE = `MSG_TYPE_NC_LOAD_REQ or `MSG_TYPE_NC_STORE_REQ.
  - MSHR id = 0.
- Header1: address field = captured address; data-size field = REQ_DATA_SIZE.
- Header2: source chipid/x/y from parameters.
- Flit progression:
  - Each flit is held stable while noc_valid_out && !noc_ready_in.
  - On acceptance, the next flit is loaded in the same edge, giving back-to-back flits with no bubbles.
  - Sequence: HDR0 -> HDR1 -> HDR2; then a load returns to IDLE, a store goes to DATA.
- DATA:
  - Sends DATA_FLITS flits, lowest 64-bit word first.
  - Each word is byte-swapped (byte 0 <-> byte 7, and so on) to match the big-endian swap on the response path.
  - A flit counter wraps to 0 after the last flit; the FSM then returns to IDLE with noc_valid_out=0, unless a new grant occurs in that same cycle.
- Descriptor:
  - transaction_type_wr pulses for exactly one cycle per packet, at grant.
  - Data = {MSG_TYPE_LOAD or MSG_TYPE_STORE, captured addr[3]}.
  - No push occurs while type_fifo_full is high.
- Simultaneous events:
  - A buffer may be refilled by a new handshake in the cycle its entry is released.
  - AR and AW/W arrivals during an in-flight packet are buffered, not dropped.
- Reset mid-packet: the packet is abandoned, noc_valid_out drops at the next edge and all buffers clear; no partial resumption.

Test Plan:
- Single load, araddr=0x8000_0008: 3 flits. Header0 has length 2 and type NC_LOAD_REQ; header1 address is 0x8000_0008; descriptor = 3'b011.
- Single store, awaddr=0x8000_0010, wdata=0x0102030405060708, W presented 2 cycles before AW: 4 flits; data flit = 0x0807060504030201; descriptor = 3'b100.
- AR and AW+W pending in the same cycle with the arbiter favouring load: load packet first, then the store packet, with no idle cycle between them.
- noc_ready_in low for 5 cycles during HDR1: noc_data_out holds header1 unchanged; flit count and order are unchanged afterwards.
- type_fifo_full high with AR pending: no flit and no push. Drop it: packet issues on the next cycle.
- Assert rst during the DATA flit of a store: next cycle noc_valid_out=0 and all ready outputs 0; after rst deasserts, all readies return to 1.
